// File: rtl/sr_reg_arbiter.sv
// Round-robin arbiter sharing one SR register among NREQ writers; s/r held HOLD_CYCLES after grant, gnt+q one cycle later.
// Requests are level-held until gnt; a write in progress is never aborted except by reset, so req/wdata changes are ignored mid-write.
module sr_reg_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*WIDTH-1:0]    wdata_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [WIDTH-1:0]         s_o,
  output logic [WIDTH-1:0]         r_o,
  output logic [WIDTH-1:0]         q_o,
  output logic                     busy_o,
  output logic [$clog2(NREQ)-1:0]  owner_o
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              found;
  logic [IW-1:0]     win;
  int                idx;

  // First asserted request scanning upward from ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    data_d  = data_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = win;
          data_d  = wdata_i[int'(win)*WIDTH +: WIDTH];
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          q_d     = data_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      data_q  <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  // s and r are complementary only while driving, so they are never both set.
  always_comb begin
    gnt_o = '0;
    s_o   = '0;
    r_o   = '0;
    if (state_q == DRIVE) begin
      s_o = data_q;
      r_o = ~data_q;
    end
    if (state_q == DONE) gnt_o[owner_q] = 1'b1;
  end

  assign q_o     = q_q;
  assign busy_o  = (state_q != IDLE);
  assign owner_o = owner_q;

endmodule

// File: tb/tb_sr_reg_arbiter.sv
// Directed table plus hand sequences and constrained-random traffic for sr_reg_arbiter.
module tb_sr_reg_arbiter;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // HOLD_CYCLES = 1 instance
  logic        rst1;
  logic [3:0]  req1;
  logic [31:0] wd1;
  logic [3:0]  g1;
  logic [7:0]  s1, r1, q1;
  logic        b1;
  logic [1:0]  o1;

  // HOLD_CYCLES = 3 instance
  logic        rst3;
  logic [3:0]  req3;
  logic [31:0] wd3;
  logic [3:0]  g3;
  logic [7:0]  s3, r3, q3;
  logic        b3;
  logic [1:0]  o3;

  sr_reg_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYCLES(1)) u1 (
    .clk_i(clk), .rst_n_i(rst1), .req_i(req1), .wdata_i(wd1),
    .gnt_o(g1), .s_o(s1), .r_o(r1), .q_o(q1), .busy_o(b1), .owner_o(o1)
  );

  sr_reg_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYCLES(3)) u3 (
    .clk_i(clk), .rst_n_i(rst3), .req_i(req3), .wdata_i(wd3),
    .gnt_o(g3), .s_o(s3), .r_o(r3), .q_o(q3), .busy_o(b3), .owner_o(o3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  s;
    logic [7:0]  r;
    logic [7:0]  q;
    logic        busy;
    logic [1:0]  owner;
  } vec_t;

  function automatic vec_t mk(input logic rn, input logic [3:0] rq, input logic [31:0] wd,
                              input logic [3:0] g, input logic [7:0] es, input logic [7:0] er,
                              input logic [7:0] eq, input logic eb, input logic [1:0] eo);
    vec_t v;
    v.rst_n = rn; v.req = rq; v.wdata = wd; v.gnt = g;
    v.s = es; v.r = er; v.q = eq; v.busy = eb; v.owner = eo;
    return v;
  endfunction

  localparam int NV = 27;
  vec_t tbl [NV];

  logic [7:0] pdata [NREQ];
  int         waits [NREQ];
  int         pcyc  [NREQ];
  bit         done_f[NREQ];
  logic [7:0] rb;

  initial begin
    logic [31:0] W0, W1, W2;
    W0 = 32'h44A52211;
    W1 = 32'h44A5223C;
    W2 = 32'h44C3223C;
    // Each row: inputs applied before an edge, outputs expected after that edge.
    tbl[0]  = mk(0, 4'b1111, W0, 4'b0000, 8'h00, 8'h00, 8'h00, 0, 2'd0);
    tbl[1]  = mk(0, 4'b1111, W0, 4'b0000, 8'h00, 8'h00, 8'h00, 0, 2'd0);
    tbl[2]  = mk(1, 4'b0100, W0, 4'b0000, 8'hA5, 8'h5A, 8'h00, 1, 2'd2);
    tbl[3]  = mk(1, 4'b0100, W0, 4'b0100, 8'h00, 8'h00, 8'hA5, 1, 2'd2);
    tbl[4]  = mk(1, 4'b0000, W0, 4'b0000, 8'h00, 8'h00, 8'hA5, 0, 2'd2);
    tbl[5]  = mk(0, 4'b0000, W0, 4'b0000, 8'h00, 8'h00, 8'h00, 0, 2'd0);
    tbl[6]  = mk(1, 4'b1010, W0, 4'b0000, 8'h22, 8'hDD, 8'h00, 1, 2'd1);
    tbl[7]  = mk(1, 4'b1010, W0, 4'b0010, 8'h00, 8'h00, 8'h22, 1, 2'd1);
    tbl[8]  = mk(1, 4'b1000, W0, 4'b0000, 8'h00, 8'h00, 8'h22, 0, 2'd1);
    tbl[9]  = mk(1, 4'b1000, W0, 4'b0000, 8'h44, 8'hBB, 8'h22, 1, 2'd3);
    tbl[10] = mk(1, 4'b1000, W0, 4'b1000, 8'h00, 8'h00, 8'h44, 1, 2'd3);
    tbl[11] = mk(1, 4'b0000, W0, 4'b0000, 8'h00, 8'h00, 8'h44, 0, 2'd3);
    tbl[12] = mk(1, 4'b1011, W0, 4'b0000, 8'h11, 8'hEE, 8'h44, 1, 2'd0);
    tbl[13] = mk(1, 4'b1011, W0, 4'b0001, 8'h00, 8'h00, 8'h11, 1, 2'd0);
    tbl[14] = mk(1, 4'b1010, W0, 4'b0000, 8'h00, 8'h00, 8'h11, 0, 2'd0);
    tbl[15] = mk(1, 4'b1010, W0, 4'b0000, 8'h22, 8'hDD, 8'h11, 1, 2'd1);
    tbl[16] = mk(1, 4'b1010, W0, 4'b0010, 8'h00, 8'h00, 8'h22, 1, 2'd1);
    tbl[17] = mk(1, 4'b1000, W0, 4'b0000, 8'h00, 8'h00, 8'h22, 0, 2'd1);
    tbl[18] = mk(1, 4'b1000, W0, 4'b0000, 8'h44, 8'hBB, 8'h22, 1, 2'd3);
    tbl[19] = mk(1, 4'b1000, W0, 4'b1000, 8'h00, 8'h00, 8'h44, 1, 2'd3);
    tbl[20] = mk(1, 4'b0000, W0, 4'b0000, 8'h00, 8'h00, 8'h44, 0, 2'd3);
    tbl[21] = mk(1, 4'b0001, W1, 4'b0000, 8'h3C, 8'hC3, 8'h44, 1, 2'd0);
    tbl[22] = mk(1, 4'b0001, W1, 4'b0001, 8'h00, 8'h00, 8'h3C, 1, 2'd0);
    tbl[23] = mk(1, 4'b0000, W1, 4'b0000, 8'h00, 8'h00, 8'h3C, 0, 2'd0);
    tbl[24] = mk(1, 4'b0100, W2, 4'b0000, 8'hC3, 8'h3C, 8'h3C, 1, 2'd2);
    tbl[25] = mk(0, 4'b0100, W2, 4'b0000, 8'h00, 8'h00, 8'h00, 0, 2'd0);
    tbl[26] = mk(1, 4'b0000, W2, 4'b0000, 8'h00, 8'h00, 8'h00, 0, 2'd0);

    rst3 = 1'b0; req3 = 4'b1111; wd3 = '0;

    for (int k = 0; k < NV; k++) begin
      rst1 = tbl[k].rst_n;
      req1 = tbl[k].req;
      wd1  = tbl[k].wdata;
      @(negedge clk);
      chk($sformatf("row%0d_gnt", k),   32'(g1), 32'(tbl[k].gnt));
      chk($sformatf("row%0d_s", k),     32'(s1), 32'(tbl[k].s));
      chk($sformatf("row%0d_r", k),     32'(r1), 32'(tbl[k].r));
      chk($sformatf("row%0d_q", k),     32'(q1), 32'(tbl[k].q));
      chk($sformatf("row%0d_busy", k),  32'(b1), 32'(tbl[k].busy));
      chk($sformatf("row%0d_owner", k), 32'(o1), 32'(tbl[k].owner));
    end

    // Long hold: HOLD_CYCLES=3 write of 8'h0F from requester 0.
    chk("h3_reset_busy", 32'(b3), 32'd0);
    chk("h3_reset_q", 32'(q3), 32'd0);
    rst3 = 1'b1; req3 = 4'b0001; wd3 = 32'h0000000F;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req3 = 4'b0001; wd3 = 32'h000000F0;  // must be ignored mid-write
      chk($sformatf("h3_drive%0d_s", k), 32'(s3), 32'h0F);
      chk($sformatf("h3_drive%0d_r", k), 32'(r3), 32'hF0);
      chk($sformatf("h3_drive%0d_gnt", k), 32'(g3), 32'd0);
    end
    @(negedge clk);
    chk("h3_done_gnt", 32'(g3), 32'b0001);
    chk("h3_done_q", 32'(q3), 32'h0F);
    chk("h3_done_s", 32'(s3), 32'd0);
    req3 = 4'b0000;
    @(negedge clk);
    chk("h3_idle_busy", 32'(b3), 32'd0);
    chk("h3_idle_gnt", 32'(g3), 32'd0);

    // Random traffic on the HOLD_CYCLES=1 instance, requesters follow the level protocol.
    req1 = '0; wd1 = '0;
    for (int i = 0; i < NREQ; i++) begin
      pdata[i] = '0; waits[i] = 0; pcyc[i] = 0; done_f[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (done_f[i]) begin
          req1[i] = 1'b0;
          done_f[i] = 1'b0;
        end
      end
      chk("rnd_s_and_r", 32'(s1 & r1), 32'd0);
      chk("rnd_gnt_onehot0", 32'($onehot0(g1)), 32'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (g1[i]) begin
          chk($sformatf("rnd_gnt%0d_pending", i), 32'(req1[i]), 32'd1);
          chk($sformatf("rnd_gnt%0d_q", i), 32'(q1), 32'(pdata[i]));
          chk($sformatf("rnd_gnt%0d_waits", i), 32'(waits[i] <= NREQ), 32'd1);
          done_f[i] = 1'b1;
          for (int j = 0; j < NREQ; j++)
            if (j != i && req1[j]) waits[j]++;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req1[i] && !done_f[i]) begin
          pcyc[i]++;
          chk($sformatf("rnd_req%0d_wait_cycles", i), 32'(pcyc[i] <= 20), 32'd1);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req1[i] && !done_f[i] && $urandom_range(2) == 0 && cyc < 560) begin
          rb = 8'($urandom_range(255));
          pdata[i] = rb;
          wd1[i*8 +: 8] = rb;
          req1[i] = 1'b1;
          waits[i] = 0;
          pcyc[i] = 0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
